// File: rtl/pixel_packet_writer_if.sv
// Byte-stream input and pixel-write bus of pixel_packet_writer, plus its status outputs.
// The stream follows valid/ready rules: a byte moves only on a cycle where in_valid & in_ready.
interface pixel_packet_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic        pkt_done;
  logic        pkt_err;
  logic [15:0] err_count;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, ctrl_en, ctrl_addr, ctrl_wdat, pkt_done, pkt_err, err_count
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, ctrl_en, ctrl_addr, ctrl_wdat, pkt_done, pkt_err, err_count
  );
endinterface

// File: rtl/pixel_packet_writer.sv
// Parses row packets {panel, row, R,G,B...} into one-cycle pixel writes on the shared panel bus.
// Malformed packets are swallowed up to in_last and reported through pkt_err / err_count.
module pixel_packet_writer #(
    parameter int WIDTH      = 96,
    parameter int HEIGHT     = 48,
    parameter int NUM_PANELS = 1
) (
    input  logic                 display_clock,
    input  logic                 reset_n,
    pixel_packet_writer_if.slave bus,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW  = 3'd1,
        S_R    = 3'd2,
        S_G    = 3'd3,
        S_B    = 3'd4,
        S_DROP = 3'd5
    } state_t;

    localparam logic [15:0] WIDTH16  = 16'(WIDTH);
    localparam logic [7:0]  LAST_COL = 8'(WIDTH - 1);
    localparam logic [7:0]  HEIGHT8  = 8'(HEIGHT);
    localparam logic [7:0]  PANELS8  = 8'(NUM_PANELS);

    state_t      state;
    logic [7:0]  panel_q;
    logic        bad_q;
    logic [15:0] row_base_q;
    logic [7:0]  col_q;
    logic [7:0]  r_q;
    logic [7:0]  g_q;
    logic        accept;
    logic        take_done;
    logic        take_err;

    assign accept    = bus.in_valid & bus.in_ready;
    assign dbg_state = state;

    // Packet outcome for the byte being accepted; only the in_last byte ends a packet.
    always_comb begin
        take_done = 1'b0;
        take_err  = 1'b0;
        if (accept && bus.in_last) begin
            case (state)
                S_ROW: begin
                    if (bad_q || bus.in_data >= HEIGHT8) take_err = 1'b1;
                    else                                 take_done = 1'b1;
                end
                S_B:     take_done = 1'b1;
                default: take_err  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge display_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            panel_q       <= '0;
            bad_q         <= 1'b0;
            row_base_q    <= '0;
            col_q         <= '0;
            r_q           <= '0;
            g_q           <= '0;
            bus.in_ready  <= 1'b0;
            bus.ctrl_en   <= '0;
            bus.ctrl_addr <= '0;
            bus.ctrl_wdat <= '0;
            bus.pkt_done  <= 1'b0;
            bus.pkt_err   <= 1'b0;
            bus.err_count <= '0;
        end else begin
            bus.in_ready <= 1'b1;
            bus.ctrl_en  <= '0;
            bus.pkt_done <= take_done;
            bus.pkt_err  <= take_err;
            if (take_err && bus.err_count != 16'hFFFF)
                bus.err_count <= bus.err_count + 16'd1;

            if (accept) begin
                case (state)
                    S_IDLE: begin
                        panel_q <= bus.in_data;
                        bad_q   <= (bus.in_data == 8'd0) || (bus.in_data > PANELS8);
                        state   <= bus.in_last ? S_IDLE : S_ROW;
                    end
                    S_ROW: begin
                        row_base_q <= {8'd0, bus.in_data} * WIDTH16;
                        col_q      <= '0;
                        if (bus.in_last)                               state <= S_IDLE;
                        else if (bad_q || bus.in_data >= HEIGHT8)      state <= S_DROP;
                        else                                           state <= S_R;
                    end
                    S_R: begin
                        r_q   <= bus.in_data;
                        state <= bus.in_last ? S_IDLE : S_G;
                    end
                    S_G: begin
                        g_q   <= bus.in_data;
                        state <= bus.in_last ? S_IDLE : S_B;
                    end
                    S_B: begin
                        bus.ctrl_en   <= panel_q;
                        bus.ctrl_addr <= row_base_q + {8'd0, col_q};
                        bus.ctrl_wdat <= {bus.in_data, g_q, r_q};
                        col_q         <= col_q + 8'd1;
                        // A full row without in_last means the packet is overlong.
                        if (bus.in_last)              state <= S_IDLE;
                        else if (col_q == LAST_COL)   state <= S_DROP;
                        else                          state <= S_R;
                    end
                    S_DROP: begin
                        if (bus.in_last) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_packet_writer.sv
// Directed bench for pixel_packet_writer: drivers push expected bus events into exp_q and a
// negedge monitor pops and compares every write / pkt_done / pkt_err the DUT presents.
module tb_pixel_packet_writer;

  localparam int EW = 50;  // {kind[1:0], en[7:0], addr[15:0], wdat[23:0]}

  logic       display_clock;
  logic       reset_n;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;
  logic [EW-1:0] exp_q[$];

  pixel_packet_writer_if bus ();

  pixel_packet_writer #(.WIDTH(96), .HEIGHT(48), .NUM_PANELS(1)) dut (
    .display_clock(display_clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial display_clock = 1'b0;
  always #5 display_clock = ~display_clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [EW-1:0] mk(input logic [1:0] kind, input logic [7:0] en,
                                       input logic [15:0] addr, input logic [23:0] wdat);
    return {kind, en, addr, wdat};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 10) begin
      @(posedge display_clock); #1;
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: actual=%b required=1", bus.in_ready);
    end
    @(posedge display_clock); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge display_clock); #1;
    end
  endtask

  task automatic send_pixel(input logic [7:0] r, g, b, input logic last,
                            input logic [15:0] addr, input int gap);
    send_byte(r, 1'b0); idle(gap);
    send_byte(g, 1'b0); idle(gap);
    exp_q.push_back(mk(2'd0, 8'd1, addr, {b, g, r}));
    if (last) exp_q.push_back(mk(2'd1, 8'd0, 16'd0, 24'd0));
    send_byte(b, last);
  endtask

  // scoreboard monitor
  task automatic pop_cmp(input string name, input logic [EW-1:0] act);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: actual=%0h required=none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        errors++;
        $display("FAIL %s: actual=%0h required=%0h", name, act, e);
      end
    end
  endtask

  always @(negedge display_clock) begin
    if (reset_n === 1'b1) begin
      if (bus.pkt_done && bus.pkt_err) begin
        checks++; errors++;
        $display("FAIL done_err_overlap: actual=11 required=not both");
      end
      if (bus.ctrl_en != 8'd0) pop_cmp("write", mk(2'd0, bus.ctrl_en, bus.ctrl_addr, bus.ctrl_wdat));
      if (bus.pkt_done)        pop_cmp("pkt_done", mk(2'd1, 8'd0, 16'd0, 24'd0));
      if (bus.pkt_err)         pop_cmp("pkt_err", mk(2'd2, 8'd0, 16'd0, 24'd0));
    end
  end

  logic [EW-1:0] err_item;
  assign err_item = mk(2'd2, 8'd0, 16'd0, 24'd0);

  initial begin
    checks = 0;
    errors = 0;
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge display_clock);
    #1;
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_ctrl_en", bus.ctrl_en, 0);
    check("reset_outputs", {bus.ctrl_addr, bus.ctrl_wdat, bus.pkt_done, bus.pkt_err}, 0);
    check("reset_err_count", bus.err_count, 0);
    check("reset_state", dbg_state, 0);
    reset_n = 1'b1;
    idle(2);
    check("ready_after_reset", bus.in_ready, 1);

    // 1: full row 5, 96 pixels, last on final B
    send_byte(8'h01, 1'b0);
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 96; i++)
      send_pixel(8'(i), 8'(i + 1), 8'(i + 2), i == 95, 16'(480 + i), 0);
    idle(2);
    check("t1_err_count", bus.err_count, 0);

    // 2: single pixel with in_valid toggled, write exactly one cycle after B
    send_byte(8'h01, 1'b0); idle(1);
    send_byte(8'h00, 1'b0); idle(1);
    send_pixel(8'h10, 8'h20, 8'h30, 1'b1, 16'd0, 1);
    check("t2_write_cycle_en", bus.ctrl_en, 1);
    check("t2_write_cycle_wdat", bus.ctrl_wdat, 24'h302010);
    idle(1);
    check("t2_en_drops", bus.ctrl_en, 0);
    check("t2_addr_holds", {bus.ctrl_addr, bus.ctrl_wdat}, {16'd0, 24'h302010});

    // 3: bad headers
    send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0);
    send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0);
    exp_q.push_back(err_item); send_byte(8'h30, 1'b1);
    send_byte(8'h02, 1'b0);
    exp_q.push_back(err_item); send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b0); send_byte(8'h30, 1'b0);
    send_byte(8'h11, 1'b0);
    exp_q.push_back(err_item); send_byte(8'h22, 1'b1);
    check("t3_err_count", bus.err_count, 3);

    // header-only packet is legal
    send_byte(8'h01, 1'b0);
    exp_q.push_back(mk(2'd1, 8'd0, 16'd0, 24'd0));
    send_byte(8'h03, 1'b1);
    idle(1);

    // 4: last row, overlong by one byte
    send_byte(8'h01, 1'b0);
    send_byte(8'h2F, 1'b0);
    for (int i = 0; i < 96; i++)
      send_pixel(8'(i), 8'h5A, 8'hC3, 1'b0, 16'(4512 + i), 0);
    check("t4_state_drop", dbg_state, 5);
    exp_q.push_back(err_item);
    send_byte(8'hEE, 1'b1);
    check("t4_err_count", bus.err_count, 4);

    // 5: last on G, then a normal packet
    send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    exp_q.push_back(err_item); send_byte(8'hBB, 1'b1);
    check("t5_err_count", bus.err_count, 5);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 16'd192, 0);
    idle(2);

    // 6: reset during G of pixel 3
    send_byte(8'h01, 1'b0); send_byte(8'h04, 1'b0);
    for (int i = 0; i < 3; i++)
      send_pixel(8'h07, 8'h08, 8'(i), 1'b0, 16'(384 + i), 0);
    send_byte(8'h44, 1'b0);
    bus.in_data = 8'h55; bus.in_valid = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge display_clock);
    check("t6_reset_ctrl_en", bus.ctrl_en, 0);
    check("t6_reset_outputs", {bus.ctrl_addr, bus.ctrl_wdat, bus.err_count}, 0);
    check("t6_reset_ready", bus.in_ready, 0);
    check("t6_reset_state", dbg_state, 0);
    bus.in_valid = 1'b0;
    idle(2);
    reset_n = 1'b1;
    send_byte(8'h01, 1'b0); send_byte(8'h06, 1'b0);
    send_pixel(8'h09, 8'h0A, 8'h0B, 1'b1, 16'd576, 0);
    idle(2);

    // saturation: 65536 one-byte error packets
    for (int i = 0; i < 65536; i++) begin
      exp_q.push_back(err_item);
      send_byte(8'h00, 1'b1);
      if (i == 65533) check("sat_fffe", bus.err_count, 16'hFFFE);
      if (i == 65534) check("sat_ffff", bus.err_count, 16'hFFFF);
    end
    check("sat_hold", bus.err_count, 16'hFFFF);
    idle(3);
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
